// File: rtl/clap_pkg.sv
`default_nettype none
// ============================================================================
// Module : clap_pkg
// Brief  : Shared types and constants for the clap timing judge and the
//          round counter that feeds it.
// Rev    : 1.0  initial release
// ============================================================================
package clap_pkg;

  // Round counter geometry, shared with counter_clap
  localparam int              CLAP_CNT_W    = 17;
  localparam logic [16:0]     CLAP_MAXCOUNT = 17'd66080;

  // Grade codes as presented on the result port
  typedef enum logic [1:0] {
    RES_NONE    = 2'd0,
    RES_MISS    = 2'd1,
    RES_GOOD    = 2'd2,
    RES_PERFECT = 2'd3
  } clap_result_e;

  // Judge state machine encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_JUDGE = 2'd2,
    ST_DONE  = 2'd3
  } clap_state_e;

endpackage : clap_pkg
`default_nettype wire

// File: rtl/clap_sync_edge.sv
`default_nettype none
// ============================================================================
// Module : clap_sync_edge
// Brief  : Three-flop synchronizer for the raw clap key with a single-cycle
//          rising-edge pulse taken from the last two stages.
// Rev    : 1.0  initial release
// ============================================================================
module clap_sync_edge (
  input  logic clk,
  input  logic resetn,
  input  logic i_async,
  output logic o_rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  // Shift the asynchronous key through three flops; s1 absorbs metastability
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // A held key yields one pulse: s2 high while s3 still remembers low
  assign o_rise = r_s2 & ~r_s3;

endmodule : clap_sync_edge
`default_nettype wire

// File: rtl/clap_judge.sv
`default_nettype none
// ============================================================================
// Module : clap_judge
// Brief  : Waits for the player's clap each round, captures the round count
//          at the clap, grades it against the target beat and maintains a
//          saturating score and hit streak.
// Rev    : 1.0  initial release
// ============================================================================
module clap_judge
  import clap_pkg::*;
#(
  parameter int               CNT_W       = CLAP_CNT_W,
  parameter logic [CNT_W-1:0] MAXCOUNT    = CLAP_MAXCOUNT,
  parameter logic [CNT_W-1:0] TARGET      = 17'd33040,
  parameter logic [CNT_W-1:0] PERFECT_WIN = 17'd500,
  parameter logic [CNT_W-1:0] GOOD_WIN    = 17'd2000,
  parameter int               PERFECT_PTS = 3,
  parameter int               GOOD_PTS    = 1,
  parameter int               SCORE_W     = 10
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [CNT_W-1:0]   count,
  input  logic               go,
  input  logic               clap,
  output logic               armed,
  output logic [1:0]         result,
  output logic               result_valid,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         streak
);

  // Point values widened to the carry-out width of the score adder
  localparam logic [SCORE_W:0] c_perfect_pts = (SCORE_W+1)'(PERFECT_PTS);
  localparam logic [SCORE_W:0] c_good_pts    = (SCORE_W+1)'(GOOD_PTS);
  localparam logic [SCORE_W:0] c_zero_pts    = '0;
  localparam logic [7:0]       c_streak_max  = 8'd255;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  clap_state_e          r_state;
  clap_state_e          w_state_nxt;

  logic                 w_rise;
  logic                 w_do_capture;
  logic                 w_do_timeout;
  logic                 w_commit;

  logic [CNT_W-1:0]     r_cap;
  logic                 r_timeout;

  logic [CNT_W-1:0]     w_diff;
  clap_result_e         w_grade;
  logic [SCORE_W:0]     w_pts;
  logic [SCORE_W:0]     w_score_sum;
  logic [SCORE_W-1:0]   w_score_nxt;
  logic [7:0]           w_streak_nxt;

  clap_result_e         r_result;
  logic                 r_valid;
  logic [SCORE_W-1:0]   r_score;
  logic [7:0]           r_streak;

  // --------------------------------------------------------------------------
  // Clap key synchronizer and edge detect
  // --------------------------------------------------------------------------
  clap_sync_edge u_sync (
    .clk     (clk),
    .resetn  (resetn),
    .i_async (clap),
    .o_rise  (w_rise)
  );

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------

  // State register; reset abandons any round in flight without grading it
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; go always restarts, a clap beats a coincident timeout
  always_comb begin
    w_state_nxt  = r_state;
    w_do_capture = 1'b0;
    w_do_timeout = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (go) begin
          w_state_nxt = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (go) begin
          w_state_nxt = ST_ARMED;
        end else if (w_rise) begin
          w_state_nxt  = ST_JUDGE;
          w_do_capture = 1'b1;
        end else if (count == MAXCOUNT) begin
          w_state_nxt  = ST_JUDGE;
          w_do_timeout = 1'b1;
        end
      end
      ST_JUDGE: begin
        // The grade commits even if a new round is requested right now
        w_commit    = 1'b1;
        w_state_nxt = go ? ST_ARMED : ST_DONE;
      end
      ST_DONE: begin
        if (go) begin
          w_state_nxt = ST_ARMED;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Capture register
  // --------------------------------------------------------------------------

  // Latch the count at the clap, or flag that the round ran out
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cap     <= '0;
      r_timeout <= 1'b0;
    end else if (w_do_capture) begin
      r_cap     <= count;
      r_timeout <= 1'b0;
    end else if (w_do_timeout) begin
      r_cap     <= count;
      r_timeout <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Grading and score arithmetic
  // --------------------------------------------------------------------------

  // Distance from the beat and the resulting grade and point award
  always_comb begin
    w_diff  = (r_cap >= TARGET) ? (r_cap - TARGET) : (TARGET - r_cap);
    w_grade = RES_MISS;
    w_pts   = c_zero_pts;
    if (r_timeout) begin
      w_grade = RES_MISS;
      w_pts   = c_zero_pts;
    end else if (w_diff <= PERFECT_WIN) begin
      w_grade = RES_PERFECT;
      w_pts   = c_perfect_pts;
    end else if (w_diff <= GOOD_WIN) begin
      w_grade = RES_GOOD;
      w_pts   = c_good_pts;
    end
  end

  // Saturating score: the extra adder bit flags overflow past full scale
  always_comb begin
    w_score_sum = {1'b0, r_score} + w_pts;
    w_score_nxt = w_score_sum[SCORE_W] ? {SCORE_W{1'b1}} : w_score_sum[SCORE_W-1:0];
  end

  // Streak grows on any hit up to 255 and drops to zero on a miss
  always_comb begin
    w_streak_nxt = r_streak;
    if (w_grade == RES_MISS) begin
      w_streak_nxt = 8'd0;
    end else if (r_streak != c_streak_max) begin
      w_streak_nxt = r_streak + 8'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Result registers
  // --------------------------------------------------------------------------

  // Commit the grade on the edge leaving JUDGE; valid follows for one cycle
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_result <= RES_NONE;
      r_valid  <= 1'b0;
      r_score  <= '0;
      r_streak <= '0;
    end else begin
      r_valid <= w_commit;
      if (w_commit) begin
        r_result <= w_grade;
        r_score  <= w_score_nxt;
        r_streak <= w_streak_nxt;
      end
    end
  end

  assign armed        = (r_state == ST_ARMED);
  assign result       = r_result;
  assign result_valid = r_valid;
  assign score        = r_score;
  assign streak       = r_streak;

endmodule : clap_judge
`default_nettype wire

// File: tb/tb_clap_judge.sv
`default_nettype none
// ============================================================================
// Module : tb_clap_judge
// Brief  : Directed self-checking bench for clap_judge.
// Rev    : 1.0  initial release
// ============================================================================
module tb_clap_judge;

  localparam logic [16:0] c_maxcount = 17'd66080;

  logic        clk;
  logic        resetn;
  logic [16:0] count;
  logic        go;
  logic        clap;
  logic        armed;
  logic [1:0]  result;
  logic        result_valid;
  logic [9:0]  score;
  logic [7:0]  streak;

  int n_checks;
  int n_errors;
  int exp_score;
  int exp_streak;

  clap_judge dut (
    .clk          (clk),
    .resetn       (resetn),
    .count        (count),
    .go           (go),
    .clap         (clap),
    .armed        (armed),
    .result       (result),
    .result_valid (result_valid),
    .score        (score),
    .streak       (streak)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge and settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model of one committed grade
  task automatic model_grade(input int res);
    if (res == 1) begin
      exp_streak = 0;
    end else begin
      exp_score  = exp_score + ((res == 3) ? 3 : 1);
      if (exp_score > 1023) exp_score = 1023;
      exp_streak = (exp_streak < 255) ? exp_streak + 1 : 255;
    end
  endtask

  task automatic pulse_go();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  // Count result_valid pulses over a window, remembering the last one
  task automatic watch(input int cycles, output int pulses, output int at,
                       output int res, output int sc, output int st);
    pulses = 0; at = -1; res = -1; sc = -1; st = -1;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (result_valid) begin
        pulses++;
        at  = i;
        res = int'(result);
        sc  = int'(score);
        st  = int'(streak);
      end
    end
  endtask

  // One armed round with a clap landing on a fixed count value
  task automatic clap_round(input string tag, input logic [16:0] cap, input int exp_res,
                            input bit verbose);
    int pulses, at, res, sc, st;
    pulse_go();
    if (verbose) check({tag, "_armed"}, int'(armed), 1);
    count = cap;
    clap  = 1'b1;
    // first watched edge samples the clap; valid expected after the third after it
    watch(3, pulses, at, res, sc, st);
    check({tag, "_early_valid"}, pulses, 0);
    clap = 1'b0;
    watch(5, pulses, at, res, sc, st);
    model_grade(exp_res);
    check({tag, "_pulses"}, pulses, 1);
    if (verbose) check({tag, "_latency"}, at, 0);
    check({tag, "_result"}, res, exp_res);
    check({tag, "_score"}, sc, exp_score);
    check({tag, "_streak"}, st, exp_streak);
  endtask

  initial begin
    int pulses, at, res, sc, st;
    n_checks   = 0;
    n_errors   = 0;
    exp_score  = 0;
    exp_streak = 0;
    resetn = 1'b0;
    go     = 1'b0;
    clap   = 1'b1;
    count  = '0;

    // Reset held two cycles with the key pressed
    tick();
    tick();
    check("rst_armed", int'(armed), 0);
    check("rst_result", int'(result), 0);
    check("rst_valid", int'(result_valid), 0);
    check("rst_score", int'(score), 0);
    check("rst_streak", int'(streak), 0);
    resetn = 1'b1;
    watch(6, pulses, at, res, sc, st);
    check("idle_clap_pulses", pulses, 0);
    check("idle_armed", int'(armed), 0);
    clap = 1'b0;
    watch(4, pulses, at, res, sc, st);

    // Perfect (diff 60), good (diff 1460), late miss (diff 2960)
    clap_round("perfect", 17'd33100, 3, 1'b1);
    check("perfect_score_abs", int'(score), 3);
    clap_round("good", 17'd34500, 2, 1'b1);
    check("good_score_abs", int'(score), 4);
    clap_round("late", 17'd36000, 1, 1'b1);
    check("late_streak_abs", int'(streak), 0);

    // Claps in DONE are ignored
    clap = 1'b1;
    watch(6, pulses, at, res, sc, st);
    clap = 1'b0;
    watch(4, pulses, at, res, sc, st);
    check("done_clap_pulses", pulses, 0);

    // Timeout: count reaches terminal value with no clap
    pulse_go();
    count = c_maxcount;
    watch(6, pulses, at, res, sc, st);
    check("timeout_pulses", pulses, 1);
    check("timeout_latency", at, 1);
    check("timeout_result", res, 1);
    check("timeout_score", sc, 4);
    count = '0;

    // Tie: rise coincides with terminal count, graded from the capture
    pulse_go();
    count = 17'd1000;
    clap  = 1'b1;
    tick();
    tick();
    count = c_maxcount;
    watch(4, pulses, at, res, sc, st);
    check("tie_pulses", pulses, 1);
    check("tie_latency", at, 1);
    check("tie_result", res, 1);
    count = '0;

    // Clap held across go: the rise was spent in DONE, so no grade
    watch(4, pulses, at, res, sc, st);
    pulse_go();
    watch(10, pulses, at, res, sc, st);
    check("held_pulses", pulses, 0);
    check("held_armed", int'(armed), 1);
    clap = 1'b0;
    watch(4, pulses, at, res, sc, st);

    // Saturation: 341 perfect rounds from score 4, streak 0
    exp_score  = 4;
    exp_streak = 0;
    for (int k = 0; k < 341; k++) begin
      clap_round("sat", 17'd33040, 3, 1'b0);
    end
    check("sat_score", int'(score), 1023);
    check("sat_streak", int'(streak), 255);

    // go while armed restarts silently
    pulse_go();
    watch(3, pulses, at, res, sc, st);
    pulse_go();
    watch(6, pulses, at, res, sc, st);
    check("restart_pulses", pulses, 0);
    check("restart_armed", int'(armed), 1);

    // go during JUDGE: grade commits and the block re-arms
    count = 17'd30000;
    clap  = 1'b1;
    tick();
    tick();
    tick();
    go = 1'b1;
    tick();
    go = 1'b0;
    check("judge_go_valid", int'(result_valid), 1);
    check("judge_go_result", int'(result), 1);
    check("judge_go_armed", int'(armed), 1);
    clap = 1'b0;
    watch(4, pulses, at, res, sc, st);

    // Reset during JUDGE discards the grade
    count = 17'd33040;
    clap  = 1'b1;
    tick();
    tick();
    tick();
    resetn = 1'b0;
    tick();
    check("rst_judge_valid", int'(result_valid), 0);
    resetn = 1'b1;
    clap   = 1'b0;
    watch(6, pulses, at, res, sc, st);
    check("rst_judge_pulses", pulses, 0);
    check("rst_judge_score", int'(score), 0);
    check("rst_judge_streak", int'(streak), 0);
    check("rst_judge_result", int'(result), 0);
    check("rst_judge_armed", int'(armed), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_clap_judge
`default_nettype wire
